// File: rtl/pc_sched_if.sv
// Control bundle between the ID-stage jump resolver / hazard unit and the PC scheduler.
// The scheduler takes the slave side; the IF/ID control outputs come back on the same bundle.
interface pc_sched_if;
    logic        set_pc;
    logic [15:0] set_pc_value;
    logic        id_valid;
    logic        hazard_stall;
    logic        mem_busy;
    logic [15:0] pc;
    logic        if_valid;
    logic        ifid_stall;
    logic        ifid_flush;
    logic [15:0] redirect_cnt;

    modport master (
        output set_pc, set_pc_value, id_valid, hazard_stall, mem_busy,
        input  pc, if_valid, ifid_stall, ifid_flush, redirect_cnt
    );

    modport slave (
        input  set_pc, set_pc_value, id_valid, hazard_stall, mem_busy,
        output pc, if_valid, ifid_stall, ifid_flush, redirect_cnt
    );
endinterface

// File: rtl/pc_sched.sv
// Program counter and fetch sequencer: boot delay, branch redirects, load-use holds,
// and fetch bubbles / deferred redirects while the shared RAM serves a data access.
module pc_sched #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int unsigned BOOT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    pc_sched_if.slave  bus
);

    typedef enum logic [1:0] {StBoot, StRun, StPend} state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] pend_pc_q, pend_pc_d;
    logic [7:0]  boot_cnt_q, boot_cnt_d;
    logic [15:0] redirect_cnt_q, redirect_cnt_d;
    logic        if_valid, ifid_stall, ifid_flush;
    logic        taken;

    // A stalled ID carries stale operands, so its branch decision is not trusted.
    assign taken = bus.set_pc & bus.id_valid & ~bus.hazard_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StBoot;
            pc_q           <= RESET_PC;
            pend_pc_q      <= 16'h0000;
            boot_cnt_q     <= 8'(BOOT_CYCLES);
            redirect_cnt_q <= 16'h0000;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            pend_pc_q      <= pend_pc_d;
            boot_cnt_q     <= boot_cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        pend_pc_d      = pend_pc_q;
        boot_cnt_d     = boot_cnt_q;
        redirect_cnt_d = redirect_cnt_q;
        if_valid       = 1'b0;
        ifid_stall     = 1'b0;
        ifid_flush     = 1'b0;

        unique case (state_q)
            StBoot: begin
                ifid_flush = 1'b1;
                boot_cnt_d = boot_cnt_q - 8'd1;
                if (boot_cnt_q == 8'd1) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (bus.hazard_stall) begin
                    ifid_stall = 1'b1;
                end else if (taken && !bus.mem_busy) begin
                    // Sequential fetch this cycle is squashed; there is no delay slot.
                    ifid_flush     = 1'b1;
                    pc_d           = bus.set_pc_value;
                    redirect_cnt_d = redirect_cnt_q + 16'd1;
                end else if (taken) begin
                    ifid_flush = 1'b1;
                    pend_pc_d  = bus.set_pc_value;
                    state_d    = StPend;
                end else if (bus.mem_busy) begin
                    ifid_flush = 1'b1;
                end else begin
                    if_valid = 1'b1;
                    pc_d     = pc_q + 16'd1;
                end
            end
            StPend: begin
                ifid_flush = 1'b1;
                if (!bus.mem_busy) begin
                    pc_d           = pend_pc_q;
                    redirect_cnt_d = redirect_cnt_q + 16'd1;
                    state_d        = StRun;
                end
            end
            default: begin
                state_d    = StBoot;
                ifid_flush = 1'b1;
            end
        endcase
    end

    assign bus.pc           = pc_q;
    assign bus.if_valid     = if_valid;
    assign bus.ifid_stall   = ifid_stall;
    assign bus.ifid_flush   = ifid_flush;
    assign bus.redirect_cnt = redirect_cnt_q;

endmodule

// File: doc/pc_sched.md
Name: pc_sched

Overview:
Owns the program counter and sequences instruction fetch for the 16-bit pipeline. It applies taken-branch redirects from the ID-stage jump resolver and holds the PC on load-use hazards. It inserts fetch bubbles while the shared RAM is occupied by a data access, and defers redirects that arrive during such a conflict. It sits between IF and ID and drives the IF/ID register control.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
BOOT_CYCLES, 4, cycles after reset release before the first fetch (RAM settle); legal range 1..255

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
set_pc  input  1  ID-stage jump resolver: branch taken
set_pc_value  input  16  ID-stage jump resolver: branch target
id_valid  input  1  ID holds a real instruction (qualifies set_pc)
hazard_stall  input  1  load-use hazard: hold PC and IF/ID
mem_busy  input  1  shared RAM used by MEM this cycle; no fetch possible
pc  output  16  fetch address (registered)
if_valid  output  1  fetch at pc is real this cycle
ifid_stall  output  1  IF/ID register holds its contents
ifid_flush  output  1  IF/ID register loads a bubble
redirect_cnt  output  16  count of applied redirects, wraps

Behaviour:
- States: BOOT, RUN, PEND. Registers: pc, pend_pc[15:0], boot_cnt[7:0], redirect_cnt, state.
- Reset (rst=0, async): pc=RESET_PC, pend_pc=0, boot_cnt=BOOT_CYCLES, redirect_cnt=0, state=BOOT. Combinational outputs while in reset or BOOT: if_valid=0, ifid_flush=1, ifid_stall=0.
- taken = set_pc & id_valid & ~hazard_stall. A stalled ID carries stale operands, so set_pc is ignored under hazard_stall.
- BOOT: boot_cnt decrements each cycle. When boot_cnt==1, go to RUN on the next edge. pc is held. All other inputs are ignored.
- RUN, priority high to low:
  1. hazard_stall=1: pc held; ifid_stall=1; ifid_flush=0; if_valid=0. hazard_stall also overrides mem_busy here: stall, not flush.
  2. taken & ~mem_busy: pc<=set_pc_value; ifid_flush=1 (the sequential fetch this cycle is squashed; no delay slot); if_valid=0; redirect_cnt+=1.
  3. taken & mem_busy: pend_pc<=set_pc_value; state<=PEND; ifid_flush=1; if_valid=0; pc held.
  4. mem_busy: pc held; ifid_flush=1; ifid_stall=0; if_valid=0.
  5. Otherwise: if_valid=1; pc<=pc+1, mod 2^16 (0xFFFF -> 0x0000); ifid_stall=0; ifid_flush=0.
- PEND: pc held; if_valid=0; ifid_flush=1; set_pc and hazard_stall ignored. When mem_busy=0: pc<=pend_pc, redirect_cnt+=1, state<=RUN. The first fetch from the target happens the cycle after PEND exits.
- Redirect latency: set_pc taken at edge N (no conflict) -> pc=target after edge N, with if_valid=1 that cycle unless it is stalled.
- ifid_stall and ifid_flush are never both 1.
- Arithmetic: all 16-bit unsigned with wrap. redirect_cnt 0xFFFF+1 -> 0x0000.
- Reset asserted mid-PEND or mid-BOOT: immediate return to reset values; the pending target is discarded.

Test Plan:
- Reset, BOOT_CYCLES=4, no stimulus -> if_valid=0 and ifid_flush=1 for 4 cycles after release, then pc runs 0000,0001,0002 with if_valid=1.
- pc=0x0010, taken with target 0x0005, mem_busy=0 -> next pc=0x0005; ifid_flush=1 in the taken cycle; redirect_cnt=1.
- set_pc=1, target 0x0040, with hazard_stall=1 for 2 cycles -> pc held, ifid_stall=1, no redirect, redirect_cnt unchanged.
- taken with target 0x0100 while mem_busy=1 for 3 cycles -> state PEND, pc held, ifid_flush=1 throughout; after mem_busy falls pc=0x0100; redirect_cnt+=1 exactly once.
- pc=0xFFFF in RUN, no events -> next pc=0x0000; redirect_cnt preloaded to 0xFFFF via 65535 redirects (or forced) plus one more redirect -> 0x0000.
- rst asserted during PEND (pend_pc=0x0100) -> pc=RESET_PC immediately; after BOOT, fetch resumes at RESET_PC, not 0x0100.
